// File: rtl/winograd_post_transform_2d_ctrl.sv
// 2D Winograd F(4,3) output transform Y = A^T * M * A for a 6x6 tile of 64-bit elements.
// One shared 1D transform serves both the row pass (LOAD) and the column pass (COL).

module winograd_post_transform_1d (
  input  logic [383:0] d,
  output logic [255:0] o
);
  logic [63:0] d0_s, d1_s, d2_s, d3_s, d4_s, d5_s;

  assign d0_s = d[63:0];
  assign d1_s = d[127:64];
  assign d2_s = d[191:128];
  assign d3_s = d[255:192];
  assign d4_s = d[319:256];
  assign d5_s = d[383:320];

  // All sums wrap modulo 2^64; signed and unsigned arithmetic coincide here.
  assign o[63:0]    = d0_s + d1_s + d2_s + d3_s + d4_s;
  assign o[127:64]  = d1_s - d2_s + (d3_s << 3'd1) - (d4_s << 3'd1);
  assign o[191:128] = d1_s + d2_s + (d3_s << 3'd2) + (d4_s << 3'd2);
  assign o[255:192] = d1_s - d2_s + (d3_s << 3'd3) - (d4_s << 3'd3) + d5_s;
endmodule

module winograd_post_transform_2d_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [383:0] in_row,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_row,
  output logic         busy
);
  typedef enum logic [1:0] {LOAD = 2'd0, COL = 2'd1, OUT = 2'd2} state_t;

  state_t      state_r;
  logic [2:0]  row_cnt_r;
  logic [1:0]  col_cnt_r;
  logic [1:0]  out_cnt_r;
  logic        in_ready_r;
  logic        out_valid_r;
  logic        busy_r;
  logic [63:0] t_r [0:5][0:3];
  logic [63:0] y_r [0:3][0:3];
  logic [383:0] tf_in_s;
  logic [255:0] tf_out_s;
  logic [255:0] out_row_s;

  winograd_post_transform_1d u_tf (
    .d (tf_in_s),
    .o (tf_out_s)
  );

  // Transform input mux: incoming row while loading, a column of T while in COL.
  always_comb begin
    tf_in_s = 384'd0;
    case (state_r)
      LOAD: tf_in_s = in_row;
      COL: begin
        for (int i = 0; i < 6; i++) begin
          tf_in_s[64*i +: 64] = t_r[i][col_cnt_r];
        end
      end
      default: tf_in_s = 384'd0;
    endcase
  end

  // Output row is a direct view of Y selected by the output row counter.
  always_comb begin
    out_row_s = 256'd0;
    for (int j = 0; j < 4; j++) begin
      out_row_s[64*j +: 64] = y_r[out_cnt_r][j];
    end
  end

  assign out_row   = out_row_s;
  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;

  // Tile FSM with counters, intermediate/result storage and registered handshake flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= LOAD;
      row_cnt_r   <= 3'd0;
      col_cnt_r   <= 2'd0;
      out_cnt_r   <= 2'd0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        for (int j = 0; j < 4; j++) begin
          t_r[i][j] <= 64'd0;
        end
      end
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < 4; j++) begin
          y_r[i][j] <= 64'd0;
        end
      end
    end else begin
      case (state_r)
        LOAD: begin
          if (in_valid && in_ready_r) begin
            for (int j = 0; j < 4; j++) begin
              t_r[row_cnt_r][j] <= tf_out_s[64*j +: 64];
            end
            if (row_cnt_r == 3'd5) begin
              row_cnt_r  <= 3'd0;
              state_r    <= COL;
              in_ready_r <= 1'b0;
              busy_r     <= 1'b1;
            end else begin
              row_cnt_r <= row_cnt_r + 3'd1;
            end
          end
        end
        COL: begin
          for (int i = 0; i < 4; i++) begin
            y_r[i][col_cnt_r] <= tf_out_s[64*i +: 64];
          end
          if (col_cnt_r == 2'd3) begin
            col_cnt_r   <= 2'd0;
            state_r     <= OUT;
            out_valid_r <= 1'b1;
          end else begin
            col_cnt_r <= col_cnt_r + 2'd1;
          end
        end
        OUT: begin
          if (out_ready) begin
            if (out_cnt_r == 2'd3) begin
              out_cnt_r   <= 2'd0;
              state_r     <= LOAD;
              out_valid_r <= 1'b0;
              busy_r      <= 1'b0;
              in_ready_r  <= 1'b1;
            end else begin
              out_cnt_r <= out_cnt_r + 2'd1;
            end
          end
        end
        default: begin
          state_r     <= LOAD;
          row_cnt_r   <= 3'd0;
          col_cnt_r   <= 2'd0;
          out_cnt_r   <= 2'd0;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_winograd_post_transform_2d_ctrl.sv
// Directed bench for winograd_post_transform_2d_ctrl; expected tiles are hand-computed.

module tb_winograd_post_transform_2d_ctrl;
  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [383:0] in_row;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] out_row;
  logic         busy;

  logic [63:0] m  [0:5][0:5];
  logic [63:0] ey [0:3][0:3];
  int n_checks = 0;
  int n_fail   = 0;

  winograd_post_transform_2d_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_row    (in_row),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_row   (out_row),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_m(input logic [63:0] v);
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++)
        m[r][c] = v;
  endtask

  task automatic clear_ey();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        ey[r][c] = 64'd0;
  endtask

  task automatic set_ey_row(input int r, input logic [63:0] a, input logic [63:0] b,
                            input logic [63:0] c, input logic [63:0] d);
    ey[r][0] = a; ey[r][1] = b; ey[r][2] = c; ey[r][3] = d;
  endtask

  // Hand-computed: every row of M*A is [5,0,10,1]; columns then give these rows.
  task automatic ey_ones();
    set_ey_row(0, 64'd25, 64'd0, 64'd50, 64'd5);
    set_ey_row(1, 64'd0, 64'd0, 64'd0, 64'd0);
    set_ey_row(2, 64'd50, 64'd0, 64'd100, 64'd10);
    set_ey_row(3, 64'd5, 64'd0, 64'd10, 64'd1);
  endtask

  task automatic drive_row(input int r);
    for (int c = 0; c < 6; c++) in_row[64*c +: 64] = m[r][c];
  endtask

  // Entered at a negedge in LOAD; leaves at the negedge of the first OUT cycle.
  task automatic send_tile(input bit gaps);
    for (int r = 0; r < 6; r++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      in_valid = 1'b1;
      drive_row(r);
      chk($sformatf("in_ready_row%0d", r), {63'd0, in_ready}, 64'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("col%0d_out_valid", i), {63'd0, out_valid}, 64'd0);
      chk($sformatf("col%0d_in_ready", i), {63'd0, in_ready}, 64'd0);
      chk($sformatf("col%0d_busy", i), {63'd0, busy}, 64'd1);
      in_valid = 1'b1;
      in_row = {384{1'b1}};
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("latency_out_valid", {63'd0, out_valid}, 64'd1);
  endtask

  task automatic recv_tile(input int stall_k, input int stall_n);
    for (int k = 0; k < 4; k++) begin
      if (k == stall_k) begin
        out_ready = 1'b0;
        repeat (stall_n) begin
          for (int j = 0; j < 4; j++)
            chk($sformatf("hold_y%0d%0d", k, j), out_row[64*j +: 64], ey[k][j]);
          chk("hold_out_valid", {63'd0, out_valid}, 64'd1);
          chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
      chk($sformatf("out_valid_k%0d", k), {63'd0, out_valid}, 64'd1);
      chk($sformatf("busy_k%0d", k), {63'd0, busy}, 64'd1);
      for (int j = 0; j < 4; j++)
        chk($sformatf("y%0d%0d", k, j), out_row[64*j +: 64], ey[k][j]);
      @(negedge clk);
    end
    chk("done_out_valid", {63'd0, out_valid}, 64'd0);
    chk("done_in_ready", {63'd0, in_ready}, 64'd1);
    chk("done_busy", {63'd0, busy}, 64'd0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    chk({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_out_row_lo"}, out_row[127:0] == 128'd0 ? 64'd0 : 64'd1, 64'd0);
    chk({tag, "_out_row_hi"}, out_row[255:128] == 128'd0 ? 64'd0 : 64'd1, 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    in_row = 384'd0;
    @(negedge clk);
    @(negedge clk);
    chk_idle("in_reset");
    rst = 1'b0;
    @(negedge clk);
    chk_idle("post_reset");

    // All-ones tile, then a delta tile back-to-back.
    fill_m(64'd1);
    ey_ones();
    send_tile(1'b0);
    recv_tile(-1, 0);
    fill_m(64'd0);
    m[0][0] = 64'd1;
    clear_ey();
    set_ey_row(0, 64'd1, 64'd0, 64'd0, 64'd0);
    send_tile(1'b0);
    recv_tile(-1, 0);

    // All-ones tile with downstream stalled for 3 cycles on row 1.
    fill_m(64'd1);
    ey_ones();
    send_tile(1'b0);
    recv_tile(1, 3);

    // Wrap-around in the row pass.
    fill_m(64'd0);
    m[0][0] = 64'h7FFF_FFFF_FFFF_FFFF;
    m[0][1] = 64'd1;
    clear_ey();
    set_ey_row(0, 64'h8000_0000_0000_0000, 64'd1, 64'd1, 64'd1);
    send_tile(1'b0);
    recv_tile(-1, 0);

    // Partial tile discarded by reset, then all-ones with input gaps.
    fill_m(64'd3);
    for (int r = 0; r < 3; r++) begin
      in_valid = 1'b1;
      drive_row(r);
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk_idle("mid_reset");
    rst = 1'b0;
    @(negedge clk);
    chk_idle("after_mid_reset");
    fill_m(64'd1);
    ey_ones();
    send_tile(1'b1);
    recv_tile(-1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
